// File: rtl/gold_seq_gen.sv
// gold_seq_gen: bit-serial length-31 Gold sequence generator feeding the DMRS
// parameter generator. Derives c_init from n_ID and the hopping mode, runs the
// Nc warm-up, then streams exactly L bits of c(n) with c_valid.
module gold_seq_gen #(
  parameter int unsigned NC          = 1600,
  parameter int unsigned N_SYMB_SLOT = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] En_hopping,
  input  logic [9:0] n_ID,
  input  logic [3:0] N_slot_frame,
  output logic       c,
  output logic       c_valid,
  output logic       busy,
  output logic       done
);

  localparam int unsigned LFSR_W = 31;
  localparam int unsigned CNT_W  = 11;
  localparam int unsigned ID_W   = 10;
  localparam int unsigned Q_W    = 6;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DIV    = 3'd1,
    S_WARMUP = 3'd2,
    S_STREAM = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   x1_q, x2_q;
  logic [ID_W-1:0]     rem_q;
  logic [Q_W-1:0]      q_q;
  logic [CNT_W-1:0]    warm_cnt_q, bit_cnt_q;
  logic [1:0]          mode_q;
  logic [3:0]          nsf_q;

  logic [CNT_W-1:0]    stream_len_c;
  logic                accept_c, div_more_c, warm_last_c, bit_last_c;
  logic [LFSR_W-1:0]   x1_shift_c, x2_shift_c;
  logic                c_d, c_valid_d, busy_d, done_d;

  // Derived conditions, stream length and one-step LFSR advances
  always_comb begin
    accept_c     = (state_q == S_IDLE) && start;
    div_more_c   = rem_q > ID_W'(29);
    warm_last_c  = warm_cnt_q == CNT_W'(NC - 1);
    stream_len_c = (mode_q == 2'd1)
                 ? CNT_W'(8 * N_SYMB_SLOT) * CNT_W'(nsf_q) + CNT_W'(8)
                 : CNT_W'(N_SYMB_SLOT) * CNT_W'(nsf_q) + CNT_W'(1);
    bit_last_c   = bit_cnt_q == (stream_len_c - CNT_W'(1));
    x1_shift_c   = {x1_q[3] ^ x1_q[0], x1_q[30:1]};
    x2_shift_c   = {x2_q[3] ^ x2_q[2] ^ x2_q[1] ^ x2_q[0], x2_q[30:1]};
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (En_hopping)
            2'd1:    state_d = S_DIV;
            2'd2:    state_d = S_WARMUP;
            default: state_d = S_FIN;
          endcase
        end
      end
      S_DIV:    if (!div_more_c) state_d = S_WARMUP;
      S_WARMUP: if (warm_last_c) state_d = S_STREAM;
      S_STREAM: if (bit_last_c)  state_d = S_FIN;
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; a disabled request enters FIN with
  // done already high, so FIN only raises done when it is not yet set
  always_comb begin
    c_d       = c;
    c_valid_d = 1'b0;
    busy_d    = busy;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          busy_d = 1'b1;
          done_d = (En_hopping != 2'd1) && (En_hopping != 2'd2);
        end
      end
      S_STREAM: begin
        c_d       = x1_q[0] ^ x2_q[0];
        c_valid_d = 1'b1;
      end
      S_FIN: begin
        busy_d = 1'b0;
        done_d = !done;
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      c       <= 1'b0;
      c_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      c       <= c_d;
      c_valid <= c_valid_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Datapath: request capture, divide-by-30, LFSR shifting and counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      x1_q       <= LFSR_W'(1);
      x2_q       <= '0;
      rem_q      <= '0;
      q_q        <= '0;
      warm_cnt_q <= '0;
      bit_cnt_q  <= '0;
      mode_q     <= '0;
      nsf_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q     <= En_hopping;
            nsf_q      <= N_slot_frame;
            rem_q      <= n_ID;
            q_q        <= '0;
            x1_q       <= LFSR_W'(1);
            warm_cnt_q <= '0;
            bit_cnt_q  <= '0;
            if (En_hopping == 2'd2) x2_q <= LFSR_W'(n_ID);
          end
        end
        S_DIV: begin
          if (div_more_c) begin
            rem_q <= rem_q - ID_W'(30);
            q_q   <= q_q + Q_W'(1);
          end else begin
            x2_q <= LFSR_W'(q_q);
          end
        end
        S_WARMUP: begin
          x1_q       <= x1_shift_c;
          x2_q       <= x2_shift_c;
          warm_cnt_q <= warm_cnt_q + CNT_W'(1);
        end
        S_STREAM: begin
          x1_q      <= x1_shift_c;
          x2_q      <= x2_shift_c;
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gold_seq_gen.sv
// tb_gold_seq_gen: randomized self-checking bench for gold_seq_gen against a
// recurrence-level Gold sequence model.
module tb_gold_seq_gen;

  localparam int NC_TB   = 1600;
  localparam int SYMB_TB = 14;
  localparam int MAXN    = 3400;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] En_hopping;
  logic [9:0] n_ID;
  logic [3:0] N_slot_frame;
  logic       c, c_valid, busy, done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  gold_seq_gen dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .En_hopping   (En_hopping),
    .n_ID         (n_ID),
    .N_slot_frame (N_slot_frame),
    .c            (c),
    .c_valid      (c_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  bit x1r [0:MAXN-1];
  bit x2r [0:MAXN-1];
  bit ref_q[$];

  // c(n) = x1(n+Nc) ^ x2(n+Nc) from the defining recurrences
  function automatic void build_ref(input int cinit, input int len);
    ref_q.delete();
    for (int i = 0; i < 31; i++) begin
      x1r[i] = (i == 0);
      x2r[i] = cinit[i];
    end
    for (int n = 0; n + 31 < NC_TB + len; n++) begin
      x1r[n+31] = x1r[n+3] ^ x1r[n];
      x2r[n+31] = x2r[n+3] ^ x2r[n+2] ^ x2r[n+1] ^ x2r[n];
    end
    for (int n = 0; n < len; n++) ref_q.push_back(x1r[n+NC_TB] ^ x2r[n+NC_TB]);
  endfunction

  function automatic int exp_len(input int mode, input int nsf);
    return (mode == 1) ? 8 * SYMB_TB * nsf + 8 : SYMB_TB * nsf + 1;
  endfunction

  function automatic int exp_cinit(input int mode, input int nid);
    return (mode == 1) ? nid / 30 : nid;
  endfunction

  // Cycle (counted as T0+1 right after the accept edge) of the first valid bit
  function automatic int exp_first(input int mode, input int nid);
    return (mode == 1) ? NC_TB + 2 + nid / 30 + 1 : NC_TB + 2;
  endfunction

  // ---------------- capture results ----------------
  bit got_q[$];
  int first_rel, done_rel, n_valid;
  bit gap, timed_out, busy_drop, busy_r1, busy2, done2, done_cv, done_busy;

  function automatic int first_diff();
    for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
      if (got_q[i] !== ref_q[i]) return i;
    return -1;
  endfunction

  // Launch one request and record what the DUT does until its done pulse
  task automatic run_capture(input logic [1:0] mode, input logic [9:0] nid,
                             input logic [3:0] nsf, input bit poke);
    int e0, rel;
    bit seen_end, poked;
    got_q.delete();
    first_rel = -1; done_rel = -1; n_valid = 0; gap = 0; timed_out = 1;
    busy_drop = 0; seen_end = 0; poked = 0; busy2 = 0; done2 = 0;
    @(negedge clk);
    En_hopping = mode; n_ID = nid; N_slot_frame = nsf; start = 1'b1;
    @(negedge clk);
    e0 = cyc;
    start = 1'b0;
    En_hopping = 2'($urandom); n_ID = 10'($urandom); N_slot_frame = 4'($urandom);
    busy_r1 = busy;
    for (int k = 0; k < 4000; k++) begin
      if (k > 0) @(negedge clk);
      if (start) start = 1'b0;
      rel = cyc - e0 + 1;
      if (c_valid) begin
        if (seen_end) gap = 1;
        if (first_rel < 0) first_rel = rel;
        got_q.push_back(c);
        n_valid++;
      end else if (first_rel >= 0) begin
        seen_end = 1;
      end
      if (!done && !busy) busy_drop = 1;
      if (done) begin
        done_rel = rel; done_cv = c_valid; done_busy = busy; timed_out = 0;
        break;
      end
      if (poke && !poked && n_valid == 40) begin
        start = 1'b1; En_hopping = 2'd1; poked = 1;
      end
    end
    if (!timed_out) begin
      @(negedge clk);
      done2 = done; busy2 = busy;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; start = 1'b1; En_hopping = 2'd2; n_ID = 10'd5; N_slot_frame = 4'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({c, c_valid, busy, done} !== 4'b0000) begin
        n_errors++;
        $display("FAIL reset_hold: outputs c/cv/busy/done=%b required 0000", {c, c_valid, busy, done});
      end
    end
    reset = 1'b1; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({c_valid, busy, done} !== 3'b000) begin
        n_errors++;
        $display("FAIL reset_idle: cv/busy/done=%b required 000", {c_valid, busy, done});
      end
    end
  endtask

  task automatic test_seq_min();
    build_ref(0, 1);
    run_capture(2'd2, 10'd0, 4'd0, 1'b0);
    n_checks++;
    if (timed_out !== 1'b0) begin n_errors++; $display("FAIL seq_min_timeout: no done seen"); end
    n_checks++;
    if (busy_r1 !== 1'b1) begin n_errors++; $display("FAIL seq_min_busy1: got %0b required 1", busy_r1); end
    n_checks++;
    if (n_valid !== 1) begin n_errors++; $display("FAIL seq_min_count: got %0d required 1", n_valid); end
    n_checks++;
    if (first_rel !== NC_TB + 2) begin n_errors++; $display("FAIL seq_min_first: got %0d required %0d", first_rel, NC_TB + 2); end
    n_checks++;
    if (got_q.size() < 1 || got_q[0] !== ref_q[0]) begin
      n_errors++; $display("FAIL seq_min_bit: got size %0d required bit %0b", got_q.size(), ref_q[0]);
    end
    n_checks++;
    if (done_rel !== NC_TB + 3) begin n_errors++; $display("FAIL seq_min_done: got %0d required %0d", done_rel, NC_TB + 3); end
    n_checks++;
    if ({done_cv, done_busy, done2, busy_drop} !== 4'b0000) begin
      n_errors++; $display("FAIL seq_min_done_cycle: cv/busy/done_next/busy_drop=%b required 0000",
                           {done_cv, done_busy, done2, busy_drop});
    end
  endtask

  task automatic test_group_max();
    int d;
    build_ref(exp_cinit(1, 1023), exp_len(1, 15));
    run_capture(2'd1, 10'd1023, 4'd15, 1'b0);
    n_checks++;
    if (n_valid !== 1688) begin n_errors++; $display("FAIL grp_count: got %0d required 1688", n_valid); end
    n_checks++;
    if (first_rel !== 1637) begin n_errors++; $display("FAIL grp_first: got %0d required 1637", first_rel); end
    n_checks++;
    if (gap !== 1'b0) begin n_errors++; $display("FAIL grp_gap: got gap=%0b required 0", gap); end
    d = first_diff();
    n_checks++;
    if (d !== -1) begin n_errors++; $display("FAIL grp_bits: first wrong bit index %0d got %0b required %0b", d, got_q[d], ref_q[d]); end
    n_checks++;
    if (done_rel !== 1637 + 1688) begin n_errors++; $display("FAIL grp_done: got %0d required %0d", done_rel, 1637 + 1688); end
  endtask

  task automatic test_seq_poke();
    int d;
    build_ref(517, exp_len(2, 9));
    run_capture(2'd2, 10'd517, 4'd9, 1'b1);
    n_checks++;
    if (n_valid !== 127) begin n_errors++; $display("FAIL poke_count: got %0d required 127", n_valid); end
    n_checks++;
    if (got_q.size() != 127 || got_q[126] !== ref_q[126]) begin
      n_errors++; $display("FAIL poke_last: got size %0d required last bit %0b", got_q.size(), ref_q[126]);
    end
    d = first_diff();
    n_checks++;
    if (d !== -1) begin n_errors++; $display("FAIL poke_bits: first wrong bit index %0d", d); end
    n_checks++;
    if (busy_drop !== 1'b0) begin n_errors++; $display("FAIL poke_busy: busy dropped early"); end
    n_checks++;
    if (busy2 !== 1'b0 || done2 !== 1'b0) begin
      n_errors++; $display("FAIL poke_requeue: after done busy=%0b done=%0b required 0 0", busy2, done2);
    end
  endtask

  task automatic test_disabled();
    logic [1:0] modes [2];
    modes[0] = 2'd3; modes[1] = 2'd0;
    for (int i = 0; i < 2; i++) begin
      run_capture(modes[i], 10'($urandom), 4'($urandom), 1'b0);
      n_checks++;
      if (done_rel !== 1 || busy_r1 !== 1'b1) begin
        n_errors++; $display("FAIL off_done: mode %0d done at %0d busy %0b required 1 1", modes[i], done_rel, busy_r1);
      end
      n_checks++;
      if (n_valid !== 0) begin n_errors++; $display("FAIL off_valid: mode %0d got %0d bits required 0", modes[i], n_valid); end
      n_checks++;
      if (busy2 !== 1'b0 || done2 !== 1'b0) begin
        n_errors++; $display("FAIL off_after: mode %0d busy=%0b done=%0b required 0 0", modes[i], busy2, done2);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cnt, d;
    bit hit, extra_done;
    logic [9:0] nid;
    nid = 10'($urandom);
    cnt = 0; hit = 0; extra_done = 0;
    @(negedge clk);
    En_hopping = 2'd2; n_ID = nid; N_slot_frame = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2500; k++) begin
      @(negedge clk);
      if (c_valid) cnt++;
      if (cnt == 50) begin hit = 1; break; end
    end
    n_checks++;
    if (!hit) begin n_errors++; $display("FAIL rst_mid_timeout: only %0d bits seen", cnt); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({c_valid, busy, done} !== 3'b000) begin
      n_errors++; $display("FAIL rst_mid_drop: cv/busy/done=%b required 000", {c_valid, busy, done});
    end
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done) extra_done = 1;
    end
    n_checks++;
    if (extra_done) begin n_errors++; $display("FAIL rst_mid_done: got done pulse required none"); end
    build_ref(nid, exp_len(2, 9));
    run_capture(2'd2, nid, 4'd9, 1'b0);
    d = first_diff();
    n_checks++;
    if (n_valid !== 127 || d !== -1) begin
      n_errors++; $display("FAIL rst_mid_rerun: got %0d bits first wrong %0d required 127 bits exact", n_valid, d);
    end
  endtask

  task automatic test_random();
    int mode, nid, nsf, d, ef, el;
    for (int it = 0; it < 4; it++) begin
      mode = 1 + (it % 2);
      nid  = $urandom_range(1023, 0);
      nsf  = $urandom_range(15, 0);
      el   = exp_len(mode, nsf);
      ef   = exp_first(mode, nid);
      build_ref(exp_cinit(mode, nid), el);
      run_capture(2'(mode), 10'(nid), 4'(nsf), 1'b0);
      d = first_diff();
      n_checks++;
      if (n_valid !== el || first_rel !== ef || gap !== 1'b0) begin
        n_errors++; $display("FAIL rand_shape: mode %0d nid %0d nsf %0d got %0d bits at %0d gap %0b required %0d bits at %0d",
                             mode, nid, nsf, n_valid, first_rel, gap, el, ef);
      end
      n_checks++;
      if (d !== -1) begin n_errors++; $display("FAIL rand_bits: mode %0d nid %0d nsf %0d first wrong index %0d", mode, nid, nsf, d); end
      n_checks++;
      if (done_rel !== ef + el) begin n_errors++; $display("FAIL rand_done: got %0d required %0d", done_rel, ef + el); end
    end
  endtask

  initial begin
    test_reset();
    test_seq_min();
    test_group_max();
    test_seq_poke();
    test_disabled();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
